instruction_fetch: RTL and testbench

//  IF stage, directly upstream of instruction decode. Owns the PC and issues in-order requests to
//  the instruction memory port. Buffers returned words in a small FIFO and presents one latched
//  {valid, instruction, pc} per cycle to decode, honouring decode's stall.

---
 rtl/instruction_fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/instruction_fetch.sv | 115 +++++++++++
 tb/tb_instruction_fetch.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared types for the instruction fetch stage: buffered fetch entries and
// the PC word type used across the front end.
package instruction_fetch_types;

    typedef logic [63:0] double_word;

    typedef struct packed {
        double_word  pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic double_word word_align(input double_word addr);
        return {addr[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch buffer holding {pc, instr} entries between the memory
// response port and the decode-facing output registers.
module fetch_fifo
    import instruction_fetch_types::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  push_data,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a full buffer can still accept.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, issues credit-limited in-order fetches, drops
// wrong-path responses after a redirect and feeds decode one word per cycle.
module instruction_fetch
    import instruction_fetch_types::*;
#(
    parameter double_word  RESET_PC   = 64'h0,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_target,
    input  logic        halt,
    input  logic        stall_in,
    output logic        pc_output_valid,
    output logic [31:0] instruction,
    output logic [63:0] instruction_pc
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    double_word    pc_q;
    double_word    resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   in_flight;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    fetch_entry_t  fifo_head;
    fetch_entry_t  resp_entry;
    logic          fire;
    logic          resp_keep;
    logic          bypass;

    // Credits cover both buffered words and requests still in flight.
    assign in_flight      = (CW + 1)'(outstanding) + (CW + 1)'(fifo_count);
    assign imem_req_valid = rst && !halt && !redirect_valid && !fifo_full
                            && (in_flight < (CW + 1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc_q;
    assign fire           = imem_req_valid && imem_req_ready;

    assign outstanding_next = outstanding + CW'(fire) - CW'(imem_resp_valid);

    assign resp_keep  = imem_resp_valid && (drop == '0);
    assign resp_entry = '{pc: resp_pc, instr: imem_resp_data};
    assign bypass     = resp_keep && fifo_empty && !stall_in;
    assign fifo_push  = resp_keep && !bypass && !redirect_valid;
    assign fifo_pop   = !stall_in && !fifo_empty && !redirect_valid;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .push_data (resp_entry),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q            <= RESET_PC;
            resp_pc         <= RESET_PC;
            outstanding     <= '0;
            drop            <= '0;
            pc_output_valid <= 1'b0;
            instruction     <= '0;
            instruction_pc  <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                // Everything still in flight after this cycle is wrong-path.
                pc_q            <= word_align(redirect_target);
                resp_pc         <= word_align(redirect_target);
                drop            <= outstanding_next;
                pc_output_valid <= 1'b0;
            end else begin
                if (fire) begin
                    pc_q <= pc_q + 64'd4;
                end
                if (resp_keep) begin
                    resp_pc <= resp_pc + 64'd4;
                end else if (imem_resp_valid) begin
                    drop <= drop - 1'b1;
                end
                if (!stall_in) begin
                    if (!fifo_empty) begin
                        pc_output_valid <= 1'b1;
                        instruction     <= fifo_head.instr;
                        instruction_pc  <= fifo_head.pc;
                    end else if (resp_keep) begin
                        pc_output_valid <= 1'b1;
                        instruction     <= resp_entry.instr;
                        instruction_pc  <= resp_entry.pc;
                    end else begin
                        pc_output_valid <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: queue-based model of requests in flight and
// buffered words, checked every cycle, plus directed literal expectations.
module tb_instruction_fetch;
    import instruction_fetch_types::*;

    localparam double_word  RST_PC = 64'h1000;
    localparam int unsigned DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_target = '0;
    logic        halt = 1'b0;
    logic        stall_in = 1'b0;
    logic        pc_output_valid;
    logic [31:0] instruction;
    logic [63:0] instruction_pc;

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt            (halt),
        .stall_in        (stall_in),
        .pc_output_valid (pc_output_valid),
        .instruction     (instruction),
        .instruction_pc  (instruction_pc)
    );

    typedef struct {
        double_word addr;
        bit         stale;
    } fly_t;

    fly_t         fly[$];
    fetch_entry_t buf_q[$];
    double_word   m_pc;
    bit           m_out_valid;
    logic [31:0]  m_out_instr;
    double_word   m_out_pc;
    bit           mem_en = 1'b1;
    int           vectors = 0;
    int           miscompares = 0;

    function automatic logic [31:0] mem_word(input double_word a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_req_valid();
        return rst && !halt && !redirect_valid && ((fly.size() + buf_q.size()) < DEPTH);
    endfunction

    task automatic model_reset();
        fly.delete();
        buf_q.delete();
        m_pc        = RST_PC;
        m_out_valid = 1'b0;
        m_out_instr = '0;
        m_out_pc    = '0;
    endtask

    task automatic check_outputs();
        chk("req_valid", imem_req_valid, m_req_valid());
        chk("req_addr", imem_req_addr, m_pc);
        chk("out_valid", pc_output_valid, m_out_valid);
        chk("instruction", instruction, m_out_instr);
        chk("instruction_pc", instruction_pc, m_out_pc);
    endtask

    task automatic model_update();
        bit           fire;
        bit           keep;
        fly_t         e;
        fetch_entry_t h;
        if (!rst) begin
            model_reset();
            return;
        end
        fire = m_req_valid() && imem_req_ready;
        keep = 1'b0;
        if (imem_resp_valid) begin
            e    = fly.pop_front();
            keep = !e.stale;
        end
        if (redirect_valid) begin
            m_pc = {redirect_target[63:2], 2'b00};
            buf_q.delete();
            m_out_valid = 1'b0;
            foreach (fly[i]) fly[i].stale = 1'b1;
        end else begin
            if (fire) begin
                fly.push_back('{addr: m_pc, stale: 1'b0});
                m_pc = m_pc + 64'd4;
            end
            if (keep) buf_q.push_back('{pc: e.addr, instr: mem_word(e.addr)});
            if (!stall_in) begin
                if (buf_q.size() > 0) begin
                    h           = buf_q.pop_front();
                    m_out_valid = 1'b1;
                    m_out_instr = h.instr;
                    m_out_pc    = h.pc;
                end else begin
                    m_out_valid = 1'b0;
                end
            end
        end
    endtask

    // One cycle: memory drives its response, outputs are checked, model advances.
    task automatic step();
        if (mem_en && rst && fly.size() > 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(fly[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        #1;
        check_outputs();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic fill_two_in_flight();
        mem_en = 1'b0;
        for (int i = 0; i < 10 && fly.size() < 2; i++) step();
        chk("two_in_flight", 64'(fly.size()), 64'd2);
    endtask

    task automatic wait_first_valid(input string name, input double_word exp_pc);
        for (int i = 0; i < 20 && !pc_output_valid; i++) step();
        chk({name, "_valid"}, pc_output_valid, 1'b1);
        chk({name, "_pc"}, instruction_pc, exp_pc);
        chk({name, "_instr"}, instruction, mem_word(exp_pc));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge clk);
        steps(2);
        chk("reset_out_valid", pc_output_valid, 1'b0);
        chk("reset_req_valid", imem_req_valid, 1'b0);

        // Stream from RESET_PC with a 1-cycle memory
        rst = 1'b1;
        #1;
        chk("first_req_valid", imem_req_valid, 1'b1);
        chk("first_req_addr", imem_req_addr, 64'h1000);
        steps(2);
        chk("first_out_valid", pc_output_valid, 1'b1);
        chk("first_out_pc", instruction_pc, 64'h1000);
        chk("first_out_instr", instruction, 64'hC0DE_1000);
        steps(6);

        // Decode stall: outputs freeze, credits run out
        stall_in = 1'b1;
        steps(3);
        stall_in = 1'b0;
        #1;
        chk("stall_no_req", imem_req_valid, 1'b0);
        steps(6);

        // Redirect with two wrong-path requests in flight
        fill_two_in_flight();
        redirect_valid  = 1'b1;
        redirect_target = 64'h2002;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("redir_addr", imem_req_addr, 64'h2000);
        mem_en = 1'b1;
        wait_first_valid("redir_first", 64'h2000);
        steps(4);

        // Memory backpressure, then a redirect inside the window
        imem_req_ready = 1'b0;
        steps(4);
        redirect_valid  = 1'b1;
        redirect_target = 64'h3000;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("bp_redir_addr", imem_req_addr, 64'h3000);
        steps(2);
        imem_req_ready = 1'b1;
        wait_first_valid("bp_first", 64'h3000);
        steps(3);

        // Back-to-back redirects, the first under stall; the later one wins
        stall_in        = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 64'h4000;
        step();
        stall_in        = 1'b0;
        redirect_target = 64'h5004;
        step();
        redirect_valid = 1'b0;
        wait_first_valid("b2b_first", 64'h5004);
        steps(3);

        // PC wraps through 2^64
        redirect_valid  = 1'b1;
        redirect_target = 64'hFFFF_FFFF_FFFF_FFFB;
        step();
        redirect_valid = 1'b0;
        wait_first_valid("wrap_first", 64'hFFFF_FFFF_FFFF_FFF8);
        steps(4);

        // Halt: buffered words drain, then nothing
        halt = 1'b1;
        steps(8);
        chk("halt_drained", pc_output_valid, 1'b0);
        chk("halt_no_req", imem_req_valid, 1'b0);
        halt = 1'b0;
        steps(3);

        // Reset mid-stream with two requests outstanding (memory resets too)
        fill_two_in_flight();
        rst = 1'b0;
        model_reset();
        #1;
        chk("midrst_out_valid", pc_output_valid, 1'b0);
        chk("midrst_instr", instruction, 64'h0);
        chk("midrst_pc", instruction_pc, 64'h0);
        chk("midrst_req_valid", imem_req_valid, 1'b0);
        steps(2);
        rst    = 1'b1;
        mem_en = 1'b1;
        #1;
        chk("rerst_req_addr", imem_req_addr, 64'h1000);
        wait_first_valid("rerst_first", 64'h1000);
        steps(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
